// File: rtl/branch_predict_unit.sv
// Execute-stage branch resolve plus a direct-mapped BTB of 2-bit counters for fetch prediction.
// Optional BPU_STATS_EN macro adds free-running branch / mispredict counters.
module branch_predict_unit #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int BTB_ENTRIES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] fetch_pc,
    output logic                  pred_taken,
    output logic [ADDR_WIDTH-1:0] pred_target,
    input  logic                  ex_valid,
    input  logic [2:0]            branch,
    input  logic                  jump,
    input  logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [DATA_WIDTH-1:0] rs2_data,
    input  logic [ADDR_WIDTH-1:0] ex_pc,
    input  logic [ADDR_WIDTH-1:0] ex_target,
    input  logic                  ex_pred_taken,
    input  logic [ADDR_WIDTH-1:0] ex_pred_target,
    output logic                  PCSrc,
    output logic                  mispredict,
    output logic [ADDR_WIDTH-1:0] redirect_pc
`ifdef BPU_STATS_EN
    ,
    output logic [31:0]           stat_branches,
    output logic [31:0]           stat_mispredicts
`endif
);

    localparam int IDX_BITS = $clog2(BTB_ENTRIES);
    localparam int TAG_BITS = ADDR_WIDTH - IDX_BITS - 2;

    typedef enum logic [2:0] {
        BR_NONE = 3'b000, BR_BEQ = 3'b001, BR_BNE  = 3'b010, BR_BLT = 3'b011,
        BR_BGE  = 3'b100, BR_BLTU = 3'b101, BR_BGEU = 3'b110, BR_RSV = 3'b111
    } br_op_e;

    logic [BTB_ENTRIES-1:0]                 btb_valid;
    logic [BTB_ENTRIES-1:0][TAG_BITS-1:0]   btb_tag;
    logic [BTB_ENTRIES-1:0][ADDR_WIDTH-1:0] btb_target;
    logic [BTB_ENTRIES-1:0][1:0]            btb_ctr;

    logic [IDX_BITS-1:0] f_idx, e_idx;
    logic [TAG_BITS-1:0] f_tag, e_tag;
    logic                f_hit, e_hit;

    assign f_idx = fetch_pc[IDX_BITS+1:2];
    assign f_tag = fetch_pc[ADDR_WIDTH-1:IDX_BITS+2];
    assign e_idx = ex_pc[IDX_BITS+1:2];
    assign e_tag = ex_pc[ADDR_WIDTH-1:IDX_BITS+2];

    // Lookup reads the registered table, so a same-cycle update is seen next cycle.
    assign f_hit       = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
    assign pred_taken  = f_hit && btb_ctr[f_idx][1];
    assign pred_target = pred_taken ? btb_target[f_idx] : '0;
    assign e_hit       = btb_valid[e_idx] && (btb_tag[e_idx] == e_tag);

    logic cond, eq, lt_s, lt_u, is_br, upd;

    assign eq    = (rs1_data == rs2_data);
    assign lt_s  = ($signed(rs1_data) < $signed(rs2_data));
    assign lt_u  = (rs1_data < rs2_data);
    assign is_br = (branch != BR_NONE) && (branch != BR_RSV);
    assign upd   = ex_valid && (is_br || jump);

    always_comb begin
        cond = 1'b0;
        case (br_op_e'(branch))
            BR_BEQ:  cond = eq;
            BR_BNE:  cond = !eq;
            BR_BLT:  cond = lt_s;
            BR_BGE:  cond = !lt_s;
            BR_BLTU: cond = lt_u;
            BR_BGEU: cond = !lt_u;
            default: cond = 1'b0;
        endcase
    end

    assign PCSrc       = ex_valid && (cond || jump);
    assign mispredict  = ex_valid && ((PCSrc != ex_pred_taken) ||
                         (PCSrc && ex_pred_taken && (ex_target != ex_pred_target)));
    assign redirect_pc = PCSrc ? ex_target : ex_pc + ADDR_WIDTH'(4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
                btb_ctr[i]    <= 2'b01;
            end
        end else if (upd) begin
            if (PCSrc) begin
                btb_target[e_idx] <= ex_target;
                if (e_hit) begin
                    btb_ctr[e_idx] <= (btb_ctr[e_idx] == 2'b11) ? 2'b11 : btb_ctr[e_idx] + 2'd1;
                end else begin
                    // Taken miss allocates, evicting any alias; jumps start strongly taken.
                    btb_valid[e_idx] <= 1'b1;
                    btb_tag[e_idx]   <= e_tag;
                    btb_ctr[e_idx]   <= jump ? 2'b11 : 2'b10;
                end
            end else if (e_hit) begin
                btb_ctr[e_idx] <= (btb_ctr[e_idx] == 2'b00) ? 2'b00 : btb_ctr[e_idx] - 2'd1;
            end
        end
    end

`ifdef BPU_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (upd)        stat_branches    <= stat_branches + 32'd1;
            if (mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Randomized + directed bench for branch_predict_unit against a table-level reference model.
module tb_branch_predict_unit;
    localparam int ENT = 64;

    logic        clk, rst;
    logic [31:0] fetch_pc, pred_target, rs1_data, rs2_data, ex_pc, ex_target, ex_pred_target, redirect_pc;
    logic        pred_taken, ex_valid, jump, ex_pred_taken, PCSrc, mispredict;
    logic [2:0]  branch;
`ifdef BPU_STATS_EN
    logic [31:0] stat_branches, stat_mispredicts;
`endif

    branch_predict_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BTB_ENTRIES(ENT)) dut (
        .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .branch(branch), .jump(jump), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
        .ex_pred_target(ex_pred_target), .PCSrc(PCSrc), .mispredict(mispredict),
        .redirect_pc(redirect_pc)
`ifdef BPU_STATS_EN
        , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Reference model: one record per table slot, counters held as plain ints 0..3.
    bit          m_valid [ENT];
    logic [31:0] m_tagv  [ENT];
    logic [31:0] m_tgt   [ENT];
    int          m_ctr   [ENT];
    int          m_nbr, m_nmis;

    function automatic int idx_of(logic [31:0] pc);
        return int'((pc / 32'd4) % ENT);
    endfunction
    function automatic logic [31:0] tag_of(logic [31:0] pc);
        return pc / (32'd4 * ENT);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < ENT; i++) begin
            m_valid[i] = 0; m_tagv[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
        end
        m_nbr = 0; m_nmis = 0;
    endfunction

    function automatic bit m_hit(logic [31:0] pc);
        return m_valid[idx_of(pc)] && (m_tagv[idx_of(pc)] == tag_of(pc));
    endfunction

    function automatic bit m_cond(logic [2:0] br, logic [31:0] a, logic [31:0] b);
        longint ua, ub, sa, sb;
        ua = {32'd0, a}; ub = {32'd0, b};
        sa = a[31] ? ua - 64'sh1_0000_0000 : ua;
        sb = b[31] ? ub - 64'sh1_0000_0000 : ub;
        case (br)
            3'd1: return ua == ub;
            3'd2: return ua != ub;
            3'd3: return sa < sb;
            3'd4: return sa >= sb;
            3'd5: return ua < ub;
            3'd6: return ua >= ub;
            default: return 0;
        endcase
    endfunction

    function automatic bit m_taken();
        return ex_valid && (m_cond(branch, rs1_data, rs2_data) || jump);
    endfunction
    function automatic bit m_mis();
        bit t = m_taken();
        return ex_valid && ((t != ex_pred_taken) || (t && ex_pred_taken && ex_target != ex_pred_target));
    endfunction
    function automatic bit m_counts();
        return ex_valid && ((branch >= 3'd1 && branch <= 3'd6) || jump);
    endfunction

    function automatic void model_update();
        int  i;
        bit  t;
        i = idx_of(ex_pc);
        t = m_taken();
        if (m_mis()) m_nmis++;
        if (!m_counts()) return;
        m_nbr++;
        if (t) begin
            if (m_hit(ex_pc)) m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
            else begin
                m_valid[i] = 1; m_tagv[i] = tag_of(ex_pc); m_ctr[i] = jump ? 3 : 2;
            end
            m_tgt[i] = ex_target;
        end else if (m_hit(ex_pc)) begin
            m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end
    endfunction

    // Called at posedge+1 with inputs set; checks before the next edge, then advances the model.
    task automatic step();
        bit          e_pt;
        logic [31:0] e_red;
        #4;
        e_pt  = m_hit(fetch_pc) && (m_ctr[idx_of(fetch_pc)] >= 2);
        e_red = m_taken() ? ex_target : ex_pc + 32'd4;
        chk("pred_taken", pred_taken, e_pt);
        chk("pred_target", pred_target, e_pt ? m_tgt[idx_of(fetch_pc)] : 32'd0);
        chk("PCSrc", PCSrc, m_taken());
        chk("mispredict", mispredict, m_mis());
        chk("redirect_pc", redirect_pc, e_red);
`ifdef BPU_STATS_EN
        chk("stat_branches", stat_branches, m_nbr);
        chk("stat_mispredicts", stat_mispredicts, m_nmis);
`endif
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_ex(input logic v, input logic [2:0] br, input logic j, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] pc, input logic [31:0] tg,
                          input logic pt, input logic [31:0] ptg);
        ex_valid = v; branch = br; jump = j; rs1_data = a; rs2_data = b;
        ex_pc = pc; ex_target = tg; ex_pred_taken = pt; ex_pred_target = ptg;
    endtask

    logic [31:0] pool [7];
    bit          exp_same [6];
    bit          exp_split [4];

    initial begin
        pool      = '{32'h000, 32'h100, 32'h200, 32'h104, 32'h300, 32'h1100, 32'hFFFF_FFFC};
        exp_same  = '{1, 0, 0, 1, 0, 1};
        exp_split = '{1, 0, 0, 1};
        rst = 1'b1; fetch_pc = 32'h100;
        set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        #2 chk("rst_pred_taken", pred_taken, 0);
        chk("rst_pred_target", pred_target, 0);
        step();

        for (int op = 1; op <= 6; op++) begin
            set_ex(1, 3'(op), 0, 5, 5, 32'h300, 32'h340, 0, 0);
            #2 chk("eq_ops_PCSrc", PCSrc, exp_same[op-1]);
            step();
        end
        for (int k = 0; k < 4; k++) begin
            set_ex(1, 3'(k + 3), 0, 32'hFFFF_FFFF, 1, 32'h300, 32'h340, 0, 0);
            #2 chk("signed_split_PCSrc", PCSrc, exp_split[k]);
            step();
        end

        // Train, then untrain, a BEQ at 0x100.
        set_ex(1, 3'd1, 0, 7, 7, 32'h100, 32'h140, 0, 0);
        #2 chk("beq_mis", mispredict, 1);
        chk("beq_redirect", redirect_pc, 32'h140);
        step();
        set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0); fetch_pc = 32'h100;
        #2 chk("trained_pt", pred_taken, 1);
        chk("trained_ptgt", pred_target, 32'h140);
        step();
        set_ex(1, 3'd1, 0, 1, 2, 32'h100, 32'h140, 1, 32'h140);
        #2 chk("nt_mis", mispredict, 1);
        chk("nt_redirect", redirect_pc, 32'h104);
        chk("nt_same_cycle_pt", pred_taken, 1);
        step();
        set_ex(1, 3'd1, 0, 1, 2, 32'h100, 32'h140, 0, 0);
        #2 chk("weak_pt", pred_taken, 0);
        chk("nt2_mis", mispredict, 0);
        step();
        set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 chk("strong_nt_pt", pred_taken, 0);
        step();

        // Alias at index 0 and read-before-write.
        set_ex(1, 3'd0, 1, 0, 0, 32'h000, 32'h0C0, 0, 0); fetch_pc = 32'h000;
        #2 chk("alias_pre_pt", pred_taken, 0);
        step();
        set_ex(1, 3'd0, 1, 0, 0, 32'h200, 32'h280, 0, 0); fetch_pc = 32'h000;
        #1 chk("alias_first_pt", pred_taken, 1);
        chk("alias_first_ptgt", pred_target, 32'h0C0);
        fetch_pc = 32'h200;
        #1 chk("rbw_old_pt", pred_taken, 0);
        step();
        set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0); fetch_pc = 32'h000;
        #2 chk("alias_evicted_pt", pred_taken, 0);
        step();
        fetch_pc = 32'h200;
        #2 chk("alias_new_pt", pred_taken, 1);
        chk("alias_new_ptgt", pred_target, 32'h280);
        step();

        // Asynchronous reset mid-update.
        set_ex(1, 3'd0, 1, 0, 0, 32'h200, 32'h2C0, 1, 32'h280);
        #2 rst = 1'b1;
        #1 chk("async_rst_pt", pred_taken, 0);
        chk("async_rst_ptgt", pred_target, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();

        // Ten counted branches with bubbles, three of them mispredicted.
        for (int i = 0; i < 10; i++) begin
            set_ex(1, 3'd2, 0, i, i, 32'h400 + 32'(4 * i), 32'h500, (i < 3), 32'h500);
            step();
            set_ex(0, 3'd1, 1, 0, 0, 32'h400, 32'h500, 1, 0);
            step();
        end
`ifdef BPU_STATS_EN
        chk("stat_branches_10", stat_branches, 10);
        chk("stat_mispredicts_3", stat_mispredicts, 3);
`endif

        for (int n = 0; n < 400; n++) begin
            logic [31:0] pc, a;
            bit          usepred;
            pc = pool[$urandom_range(0, 6)];
            a  = $urandom;
            usepred = ($urandom_range(0, 1) == 1);
            set_ex(($urandom_range(0, 4) != 0), 3'($urandom_range(0, 7)), ($urandom_range(0, 4) == 0),
                   a, ($urandom_range(0, 2) == 0) ? a : $urandom, pc,
                   ($urandom_range(0, 1) == 1) ? 32'h40 : ($urandom & 32'hFFFF_FFFC), 0, 0);
            if (usepred) begin
                ex_pred_taken  = m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
                ex_pred_target = ex_pred_taken ? m_tgt[idx_of(pc)] : 32'd0;
            end else begin
                ex_pred_taken  = 1'($urandom_range(0, 1));
                ex_pred_target = ($urandom_range(0, 1) == 1) ? ex_target : 32'h80;
            end
            fetch_pc = ($urandom_range(0, 2) == 0) ? pc : pool[$urandom_range(0, 6)];
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
Parametrised successor to the execute-stage branch decision logic. It resolves all six RV32I conditional branches plus jumps from raw operands, and predicts fetch-stage branches with a direct-mapped BTB of 2-bit saturating counters. On a wrong prediction it flags a mispredict with a redirect PC. Lookup sits beside the fetch PC register; resolve and update sit in execute.

Parameters:
ADDR_WIDTH, 32, PC/target width
DATA_WIDTH, 32, operand width
BTB_ENTRIES, 64, table depth; power of 2, >=4; IDX_BITS=log2(BTB_ENTRIES), TAG_BITS=ADDR_WIDTH-IDX_BITS-2

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
fetch_pc  in  ADDR_WIDTH  PC being fetched
pred_taken  out  1  prediction for fetch_pc
pred_target  out  ADDR_WIDTH  predicted target (0 when pred_taken=0)
ex_valid  in  1  execute slot holds a live instruction
branch  in  3  000 NONE, 001 BEQ, 010 BNE, 011 BLT, 100 BGE, 101 BLTU, 110 BGEU, 111 reserved
jump  in  1  unconditional jump (JAL/JALR)
rs1_data  in  DATA_WIDTH  operand A
rs2_data  in  DATA_WIDTH  operand B
ex_pc  in  ADDR_WIDTH  PC of execute instruction
ex_target  in  ADDR_WIDTH  computed target
ex_pred_taken  in  1  prediction carried down pipeline
ex_pred_target  in  ADDR_WIDTH  predicted target carried down
PCSrc  out  1  actual taken (branch condition | jump), gated by ex_valid
mispredict  out  1  flush request
redirect_pc  out  ADDR_WIDTH  PCSrc ? ex_target : ex_pc+4

Behaviour:
- Entry: valid, tag[TAG_BITS], target[ADDR_WIDTH], ctr[2]. idx = pc[IDX_BITS+1:2], tag = pc[ADDR_WIDTH-1:IDX_BITS+2].
- Lookup combinational: hit = valid & tag match; pred_taken = hit & ctr[1]; pred_target = pred_taken ? target : 0.
- Resolve combinational: BEQ eq; BNE !eq; BLT signed a<b; BGE signed a>=b; BLTU unsigned a<b; BGEU unsigned a>=b; NONE/111 -> 0. PCSrc = ex_valid & (cond | jump).
- mispredict = ex_valid & ((PCSrc != ex_pred_taken) | (PCSrc & ex_pred_taken & ex_target != ex_pred_target)). Zero when ex_valid=0.
- redirect_pc: ex_pc+4 wraps modulo 2^ADDR_WIDTH.
- Update on rising clk when ex_valid & (branch in 001..110 | jump), at idx(ex_pc):
  - taken & hit: ctr sat-increment (max 11), target <= ex_target.
  - taken & miss: allocate/overwrite: valid=1, tag, target, ctr=10 (branch) or 11 (jump).
  - not taken & hit: ctr sat-decrement (min 00); valid stays 1.
  - not taken & miss: no write.
  - branch=111 or NONE without jump: no write.
- Same idx looked up and updated in one cycle: lookup returns pre-update contents (read-before-write); new value visible next cycle.
- Aliasing: different tag, same idx -> miss, taken resolve evicts.
- Reset (asynchronous, any time incl. mid-update): all valid=0, ctr=01, target=0, tag=0; pred_taken=0, pred_target=0 immediately. Combinational resolve outputs follow inputs.
- No stall port: upstream deasserts ex_valid for bubbles/stalls.

Optional Feature:
BPU_STATS_EN: when defined, adds outputs stat_branches [31:0] and stat_mispredicts [31:0]. Each increments by 1 per cycle with ex_valid & (conditional branch | jump), and with mispredict, respectively. Both wrap at 2^32 and reset asynchronously to 0. When undefined, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then fetch_pc=0x100 -> pred_taken=0, pred_target=0; all six branch ops with rs1=rs2=5 -> PCSrc 1,0,0,1,0,1 respectively.
- Signed/unsigned split: rs1=0xFFFFFFFF, rs2=1 -> BLT=1, BGE=0, BLTU=0, BGEU=1.
- BEQ at ex_pc=0x100, target 0x140, taken, ex_pred_taken=0 -> mispredict=1, redirect_pc=0x140. Next cycle fetch_pc=0x100 -> pred_taken=1, pred_target=0x140 (ctr=10).
- Same branch then not taken twice -> ctr 10->01->00; fetch 0x100 gives pred_taken=0; the not-taken resolve with ex_pred_taken=1 -> mispredict=1, redirect_pc=0x104.
- Alias: 64 entries, taken jump at 0x200 (idx 0, different tag from 0x000) -> fetch 0x000 misses; simultaneous lookup and update of 0x200 returns old entry that cycle; assert rst mid-sequence -> pred_taken=0 at once.
- With BPU_STATS_EN: 10 branches, 3 mispredicts, ex_valid=0 cycles interleaved -> stat_branches=10, stat_mispredicts=3.
